// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer
// Front end and back end for a combinational ripple-carry adder. A debounced pushbutton
// loads operand A, then operand B with carry-in. One cycle later the adder's sum,
// carry-out and signed overflow are registered and held for display. Pressing the button
// again starts a new operation, beginning with a new operand A.
module adder_operand_sequencer #(
  parameter int WIDTH        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_btn_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             c_in_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             result_vld_o,
  output logic [1:0]       state_o
);

  localparam int CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    ADD    = 2'b10,
    SHOW   = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   deb;
  logic [CNT_W-1:0]       deb_cnt;
  logic                   deb_prev;
  logic                   armed;
  logic [CNT_W-1:0]       arm_cnt;
  logic                   press;

  state_t state, next_state;
  logic   load_a, load_b, do_add, clr_vld;
  logic   ovf_next;

  // Bring the asynchronous button into the clock domain. Reset loads "released".
  // NOTE: every clocked block uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], load_btn_n};
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Debounce: accept a new level only after it has differed from deb for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= 1'b1;
      deb_cnt <= '0;
    end else if (btn_s != deb) begin
      if (deb_cnt == CNT_MAX) begin
        deb     <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Arm press detection only after the debounced button has been seen released for a full
  // debounce window, so a button held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (btn_s && deb) begin
        if (arm_cnt == CNT_MAX) armed <= 1'b1;
        else                    arm_cnt <= arm_cnt + CNT_W'(1);
      end else begin
        arm_cnt <= '0;
      end
    end
  end

  // One-cycle press pulse on the debounced 1->0 edge; release edges are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      deb_prev <= deb;
      press    <= armed & deb_prev & ~deb;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_A;
    else        state <= next_state;
  end

  // Next-state and capture strobes. A press during ADD is intentionally dropped.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    do_add     = 1'b0;
    clr_vld    = 1'b0;
    case (state)
      WAIT_A: begin
        if (press) begin
          load_a     = 1'b1;
          next_state = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          load_b     = 1'b1;
          next_state = ADD;
        end
      end
      ADD: begin
        do_add     = 1'b1;
        next_state = SHOW;
      end
      SHOW: begin
        if (press) begin
          load_a     = 1'b1;
          clr_vld    = 1'b1;
          next_state = WAIT_B;
        end
      end
      default: next_state = WAIT_A;
    endcase
  end

  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf_next = (a_o[WIDTH-1] == b_o[WIDTH-1]) && (sum_i[WIDTH-1] != a_o[WIDTH-1]);

  // Operand and result registers. Operands never move in ADD, so sum_i is settled there.
  // NOTE: all of these are plain registers, so all are reset; nothing here is a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_o          <= '0;
      b_o          <= '0;
      c_in_o       <= 1'b0;
      result_o     <= '0;
      carry_o      <= 1'b0;
      ovf_o        <= 1'b0;
      result_vld_o <= 1'b0;
    end else begin
      if (load_a) a_o <= data_i;
      if (load_b) begin
        b_o    <= data_i;
        c_in_o <= cin_i;
      end
      if (do_add) begin
        result_o     <= sum_i;
        carry_o      <= cout_i;
        ovf_o        <= ovf_next;
        result_vld_o <= 1'b1;
      end else if (clr_vld) begin
        result_vld_o <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Self-checking bench for adder_operand_sequencer. The combinational adder is modelled
// here; expected results come from plain integer arithmetic on the operands pressed in.
module tb_adder_operand_sequencer;

  localparam int WIDTH     = 4;
  localparam int SYNC      = 2;
  localparam int DEB       = 16;
  // Edges from a clean fall (driven between edges) until state_o shows the transition:
  // press pulse after SYNC+DEB+1 edges, state register one edge later.
  localparam int STATE_LAT = SYNC + DEB + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_btn_n = 1'b1;
  logic [WIDTH-1:0] data_i = '0;
  logic             cin_i = 1'b0;
  logic [WIDTH-1:0] a_o, b_o, sum_i, result_o;
  logic             c_in_o, cout_i, carry_o, ovf_o, result_vld_o;
  logic [1:0]       state_o;
  logic [WIDTH:0]   add_full;

  int checks = 0;
  int errors = 0;

  // Expected-state bookkeeping kept by the bench.
  logic [1:0]       exp_state = 2'd0;
  bit               have_res  = 1'b0;
  logic [WIDTH-1:0] exp_a = '0;
  logic [WIDTH-1:0] exp_res = '0;
  logic             exp_carry = 1'b0;
  logic             exp_ovf = 1'b0;

  adder_operand_sequencer #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_btn_n   (load_btn_n),
    .data_i       (data_i),
    .cin_i        (cin_i),
    .a_o          (a_o),
    .b_o          (b_o),
    .c_in_o       (c_in_o),
    .sum_i        (sum_i),
    .cout_i       (cout_i),
    .result_o     (result_o),
    .carry_o      (carry_o),
    .ovf_o        (ovf_o),
    .result_vld_o (result_vld_o),
    .state_o      (state_o)
  );

  // The ripple-carry adder the sequencer drives.
  assign add_full = {1'b0, a_o} + {1'b0, b_o} + {{WIDTH{1'b0}}, c_in_o};
  assign sum_i    = add_full[WIDTH-1:0];
  assign cout_i   = add_full[WIDTH];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference arithmetic: unsigned sum mod 2^WIDTH, carry out, signed overflow.
  task automatic model(input int a, input int b, input int c);
    int full, sa, sb, s;
    full      = a + b + c;
    exp_res   = full[WIDTH-1:0];
    exp_carry = full[WIDTH];
    sa        = (a >= 8) ? a - 16 : a;
    sb        = (b >= 8) ? b - 16 : b;
    s         = sa + sb + c;
    exp_ovf   = (s > 7) || (s < -8);
  endtask

  // Hold the button low until state_o moves away from exp_state; returns edges taken (0 = never).
  task automatic hold_until_move(output int lat);
    lat = 0;
    load_btn_n = 1'b0;
    for (int k = 1; k <= 3 * STATE_LAT; k++) begin
      tick(1);
      if (state_o != exp_state) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_btn();
    tick(4);
    load_btn_n = 1'b1;
    tick(3 * DEB);
  endtask

  // Operand A press (from WAIT_A or SHOW), optionally preceded by a bouncing contact.
  task automatic press_a(input logic [WIDTH-1:0] a, input bit bounce);
    int lat;
    data_i = a;
    cin_i  = 1'($urandom_range(0, 1));
    if (bounce) begin
      for (int i = 0; i < 14; i++) begin
        load_btn_n = ~load_btn_n;
        tick(3);
      end
    end
    hold_until_move(lat);
    check("a_press_latency", lat, STATE_LAT);
    check("a_state", state_o, 2'd1);
    check("a_o", a_o, a);
    if (have_res) begin
      check("vld_drop", result_vld_o, 1'b0);
      check("result_held", result_o, exp_res);
    end
    exp_a     = a;
    exp_state = 2'd1;
    data_i    = ~a;
    release_btn();
    check("a_single_press", state_o, 2'd1);
    check("a_stable", a_o, exp_a);
  endtask

  // Operand B press: ADD on the next cycle, valid result the cycle after.
  task automatic press_b(input logic [WIDTH-1:0] b, input logic c);
    int lat;
    data_i = b;
    cin_i  = c;
    hold_until_move(lat);
    check("b_press_latency", lat, STATE_LAT);
    check("add_state", state_o, 2'd2);
    check("vld_low_in_add", result_vld_o, 1'b0);
    check("b_o", b_o, b);
    check("c_in_o", c_in_o, c);
    check("a_kept", a_o, exp_a);
    model(int'(exp_a), int'(b), int'(c));
    tick(1);
    check("show_state", state_o, 2'd3);
    check("result_vld", result_vld_o, 1'b1);
    check("result", result_o, exp_res);
    check("carry", carry_o, exp_carry);
    check("ovf", ovf_o, exp_ovf);
    have_res  = 1'b1;
    exp_state = 2'd3;
    release_btn();
    check("show_hold_state", state_o, 2'd3);
    check("show_hold_result", result_o, exp_res);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    press_a(a, 1'b0);
    press_b(b, c);
  endtask

  initial begin
    tick(3);
    check("rst_state", state_o, 2'd0);
    check("rst_a", a_o, 0);
    check("rst_vld", result_vld_o, 1'b0);
    rst_n = 1'b1;
    tick(3 * DEB);

    // A glitch one cycle short of the debounce window is ignored.
    load_btn_n = 1'b0;
    tick(DEB - 1);
    load_btn_n = 1'b1;
    tick(3 * DEB);
    check("glitch_no_press", state_o, 2'd0);

    // Bouncing contact before A, then the directed arithmetic cases.
    press_a(4'h7, 1'b1);
    press_b(4'h9, 1'b0);
    run_op(4'h7, 4'h1, 1'b0);
    run_op(4'h8, 4'h8, 1'b0);
    run_op(4'hF, 4'hF, 1'b1);
    run_op(4'h0, 4'h0, 1'b1);

    // Re-run from SHOW with A=3.
    press_a(4'h3, 1'b0);
    press_b(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 8; i++)
      run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Asynchronous reset in SHOW with the button held low through reset release.
    load_btn_n = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", state_o, 2'd0);
    check("async_rst_a", a_o, 0);
    check("async_rst_b", b_o, 0);
    check("async_rst_cin", c_in_o, 1'b0);
    check("async_rst_res", result_o, 0);
    check("async_rst_carry", carry_o, 1'b0);
    check("async_rst_ovf", ovf_o, 1'b0);
    check("async_rst_vld", result_vld_o, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(4 * DEB);
    check("held_no_press", state_o, 2'd0);
    load_btn_n = 1'b1;
    tick(4 * DEB);
    check("released_no_press", state_o, 2'd0);
    have_res  = 1'b0;
    exp_state = 2'd0;

    run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
